// File: rtl/udp_tx_pkg.sv
// Shared encodings for the UDP transmit scheduler.
// Holds sender state codes, length limits and the scheduler state enum.
package udp_tx_pkg;

    localparam logic [3:0] TX_IDLE    = 4'd0;
    localparam logic [3:0] TX_START   = 4'd1;
    localparam logic [3:0] TX_ETH_HDR = 4'd2;
    localparam logic [3:0] TX_IP_HDR  = 4'd3;
    localparam logic [3:0] TX_UDP_HDR = 4'd4;
    localparam logic [3:0] TX_PAYLOAD = 4'd5;
    localparam logic [3:0] TX_PAD     = 4'd6;
    localparam logic [3:0] TX_SENDCRC = 4'd7;

    localparam logic [15:0] UDP_LEN_MIN = 16'd9;
    localparam logic [15:0] UDP_LEN_MAX = 16'd1480;
    localparam logic [15:0] IP_HDR_LEN  = 16'd20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_BUSY,
        S_GAP
    } sched_state_t;

    function automatic logic len_ok(input logic [15:0] len);
        return (len >= UDP_LEN_MIN) && (len <= UDP_LEN_MAX);
    endfunction

endpackage

// File: rtl/udp_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping.
// Pure combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] k;

    // Scan from the far end so the slot nearest ptr wins last.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        k     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % N);
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = k;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Arbitrates requesters onto one UDP/IP frame sender.
// Enforces length limits, inter-frame gap and per-phase timeout.
module udp_tx_scheduler
    import udp_tx_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*16-1:0]      req_len,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         rej,
    output logic                       timeout_err,
    output logic                       i_pkg_send_udp_req,
    output logic [15:0]                tx_data_length,
    output logic [15:0]                tx_total_length,
    input  logic [3:0]                 tx_state,
    output logic [$clog2(NUM_REQ)-1:0] buf_sel
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [31:0]   TO_LAST  = TIMEOUT_CYCLES - 1;
    localparam logic [31:0]   IFG_LAST = IFG_CYCLES - 1;

    sched_state_t       state, state_n;
    logic [IW-1:0]      ptr, ptr_n;
    logic [31:0]        cnt, cnt_n;
    logic [NUM_REQ-1:0] grant_n, done_n, rej_n;
    logic               to_n, send_n;
    logic [15:0]        dl_n, tl_n, win_len;
    logic [IW-1:0]      bs_n;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        win_len = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_idx == IW'(k)) win_len = req_len[16*k +: 16];
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        grant_n = grant;
        done_n  = '0;
        rej_n   = '0;
        to_n    = 1'b0;
        send_n  = i_pkg_send_udp_req;
        dl_n    = tx_data_length;
        tl_n    = tx_total_length;
        bs_n    = buf_sel;
        unique case (state)
            S_IDLE: begin
                if (|req && tx_state == TX_IDLE) state_n = S_ARB;
            end
            S_ARB: begin
                if (!arb_valid) begin
                    state_n = S_IDLE;
                end else begin
                    ptr_n = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
                    if (len_ok(win_len)) begin
                        dl_n    = win_len;
                        tl_n    = win_len + IP_HDR_LEN;
                        grant_n = arb_gnt;
                        bs_n    = arb_idx;
                        send_n  = 1'b1;
                        cnt_n   = '0;
                        state_n = S_LAUNCH;
                    end else begin
                        rej_n   = arb_gnt;
                        state_n = S_IDLE;
                    end
                end
            end
            S_LAUNCH: begin
                if (tx_state != TX_IDLE) begin
                    send_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = S_BUSY;
                end else if (cnt == TO_LAST) begin
                    to_n    = 1'b1;
                    send_n  = 1'b0;
                    grant_n = '0;
                    cnt_n   = '0;
                    state_n = S_GAP;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            S_BUSY: begin
                if (tx_state == TX_IDLE) begin
                    done_n  = grant;
                    grant_n = '0;
                    cnt_n   = '0;
                    state_n = S_GAP;
                end else if (cnt == TO_LAST) begin
                    to_n    = 1'b1;
                    grant_n = '0;
                    cnt_n   = '0;
                    state_n = S_GAP;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            S_GAP: begin
                if (cnt == IFG_LAST) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            ptr                <= '0;
            cnt                <= '0;
            grant              <= '0;
            done               <= '0;
            rej                <= '0;
            timeout_err        <= 1'b0;
            i_pkg_send_udp_req <= 1'b0;
            tx_data_length     <= '0;
            tx_total_length    <= '0;
            buf_sel            <= '0;
        end else begin
            state              <= state_n;
            ptr                <= ptr_n;
            cnt                <= cnt_n;
            grant              <= grant_n;
            done               <= done_n;
            rej                <= rej_n;
            timeout_err        <= to_n;
            i_pkg_send_udp_req <= send_n;
            tx_data_length     <= dl_n;
            tx_total_length    <= tl_n;
            buf_sel            <= bs_n;
        end
    end

endmodule

// File: doc/udp_tx_scheduler.md
UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters (2..8).
REQ-002 Parameter IFG_CYCLES, default 12, is the minimum idle clocks between frames.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, is the maximum clocks allowed per frame phase.
REQ-004 The module shall have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  the GMII transmit clock; all logic is on posedge.
REQ-006 rst_n  in  1  the asynchronous active-low reset.
REQ-007 req  in  NUM_REQ  per-requester send request, level, held until done or rej.
REQ-008 req_len  in  NUM_REQ*16  per-requester UDP length (8-byte UDP header plus payload), slice k = [16k+15:16k].
REQ-009 grant  out  NUM_REQ  one-hot owner of the transmit datapath; all zero when no owner.
REQ-010 done  out  NUM_REQ  one-cycle pulse when the owner's frame has completed.
REQ-011 rej  out  NUM_REQ  one-cycle pulse when a request is refused for an illegal length.
REQ-012 timeout_err  out  1  one-cycle pulse when a frame phase exceeds TIMEOUT_CYCLES.
REQ-013 i_pkg_send_udp_req  out  1  start request to the UDP/IP frame sender.
REQ-014 tx_data_length  out  16  UDP length driven to the sender.
REQ-015 tx_total_length  out  16  IP total length driven to the sender.
REQ-016 tx_state  in  4  sender state; 0 = idle, 1 = start, 7 = sendcrc.
REQ-017 buf_sel  out  $clog2(NUM_REQ)  index of the owner, used to select its payload RAM.

Function
REQ-018 The FSM shall have the states IDLE, ARB, LAUNCH, BUSY and GAP.
REQ-019 IDLE: if any req bit is 1 and tx_state == 0, go to ARB on the next clock.
REQ-020 ARB: pick the winner round-robin, starting from the index after the last winner (index 0 after reset).
REQ-021 ARB: the winner's req_len shall be legal when 9 <= len <= 1480.
- Legal: latch the length into tx_data_length and len+20 into tx_total_length, set grant and buf_sel, go to LAUNCH.
- Illegal: pulse rej for the winner, advance the round-robin pointer, return to IDLE; no sender activity.
REQ-022 LAUNCH: assert i_pkg_send_udp_req; deassert it on the first clock that samples tx_state != 0, then go to BUSY.
REQ-023 BUSY: the first clock that samples tx_state == 0 shall pulse done for the owner, clear grant, and go to GAP.
REQ-024 GAP: count IFG_CYCLES clocks, then go to IDLE; requests during GAP are held, not lost.
REQ-025 tx_data_length, tx_total_length and buf_sel shall stay constant from ARB exit until GAP exit.
REQ-026 Latency: IDLE with req asserted to i_pkg_send_udp_req high is exactly 2 clocks.
REQ-027 A timeout counter resets on LAUNCH and BUSY entry.
- On reaching TIMEOUT_CYCLES: pulse timeout_err, drop i_pkg_send_udp_req and grant, give no done, go to GAP.
REQ-028 If the owner's req drops mid-frame, the frame completes and done still pulses; a frame is never aborted.
REQ-029 Simultaneous requests shall be served one frame each, in round-robin order; no requester waits more than NUM_REQ-1 frames.
REQ-030 tx_total_length arithmetic is 16-bit; the legality check guarantees no overflow.

Reset
REQ-031 While rst_n = 0, the FSM shall be in IDLE.
REQ-032 While rst_n = 0, grant, done, rej, timeout_err and i_pkg_send_udp_req shall be 0, and tx_data_length, tx_total_length and buf_sel shall be 0.
REQ-033 While rst_n = 0, the round-robin pointer shall point at requester 0 and the counters shall be 0.
REQ-034 Reset mid-frame shall take effect immediately; after release the FSM waits in IDLE until tx_state == 0.

Structure
REQ-035 The shared package udp_tx_pkg shall hold the sender state encodings (idle..sendcrc), UDP_LEN_MIN = 9, UDP_LEN_MAX = 1480, IP_HDR_LEN = 20 and the scheduler state enum.
REQ-036 Round-robin selection shall be one sub-module, rr_arbiter (request vector, pointer, one-hot grant, index).

Verification
REQ-037 Single request: req[0] = 1 with len 64 -> i_pkg_send_udp_req 2 clocks later, tx_data_length = 64, tx_total_length = 84; model the sender with tx_state = 1 for 100 clocks, then 0 -> done[0] pulses once, then ≥ 12 idle clocks.
REQ-038 All four requesting with lens 100/200/300/400 -> grant order 0, 1, 2, 3; each done pulses once; IFG of ≥ 12 clocks between launches.
REQ-039 Illegal lengths: req[2] with len 8 -> rej[2] pulse, no send request; len 1481 -> rej[2]; len 9 and len 1480 are accepted.
REQ-040 Hung sender: tx_state held at 0 after launch (TIMEOUT_CYCLES = 64) -> timeout_err pulses at 64 clocks, grant clears, next requester is served.
REQ-041 rst_n low during BUSY -> all outputs are 0 asynchronously; after release, with tx_state still nonzero, no launch occurs until tx_state == 0.
